// File: rtl/ex_muldiv.sv
// RV32M execute unit: iterative shift-add multiply and restoring divide, one bit per cycle.
// Stalls the pipeline through hold_flag_o while iterating; one-cycle write-back strobe in DONE.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wen_o,
  output logic            busy_o,
  output logic            hold_flag_o
);

  typedef enum logic [1:0] {IDLE, CALC, CORR, DONE} state_e;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg1_q, neg1_d;
  logic                neg2_q, neg2_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     rd_data_q, rd_data_d;
  logic [4:0]          rd_addr_q, rd_addr_d;

  logic                sgn1, sgn2, neg1, neg2;
  logic [XLEN-1:0]     abs1, abs2;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     special_res;

  logic [XLEN:0]       mul_sum, rem_shift, div_diff;

  logic                sign_diff;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, result;

  always_comb begin
    sgn1 = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    sgn2 = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    neg1 = sgn1 && op1_i[XLEN-1];
    neg2 = sgn2 && op2_i[XLEN-1];
    abs1 = neg1 ? -op1_i : op1_i;
    abs2 = neg2 ? -op2_i : op2_i;
    div_zero = op_i[2] && (op2_i == '0);
    div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) && (op1_i == INT_MIN) && (op2_i == '1);
    special  = div_zero || div_ovf;
    special_res = '0;
    // op_i[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero) begin
      special_res = op_i[1] ? op1_i : '1;
    end else if (div_ovf) begin
      special_res = op_i[1] ? '0 : op1_i;
    end
  end

  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = rem_shift - {1'b0, b_q};
  end

  always_comb begin
    sign_diff = neg1_q ^ neg2_q;
    prod_fix  = sign_diff ? -acc_q : acc_q;
    quo_fix   = sign_diff ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix   = neg1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quo_fix;
      default:                      result = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rd_data_d = rd_data_q;
    rd_addr_d = rd_addr_q;

    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        CALC: begin
          if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
              acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
              acc_d = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d = CORR;
          end
        end
        CORR: begin
          rd_data_d = result;
          state_d   = DONE;
        end
        default: begin
          if (state_q == DONE) begin
            state_d = IDLE;
          end
          // IDLE and DONE accept a new operation under identical rules
          if (start_i) begin
            op_d      = op_i;
            rd_addr_d = rd_addr_i;
            neg1_d    = neg1;
            neg2_d    = neg2;
            b_d       = abs2;
            acc_d     = {{XLEN{1'b0}}, abs1};
            cnt_d     = '0;
            if (special) begin
              rd_data_d = special_res;
              state_d   = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
      rd_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rd_data_q <= rd_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_wen_o    = (state_q == DONE) && !flush_i;
  assign busy_o      = (state_q != IDLE);
  assign hold_flag_o = !flush_i &&
                       (((state_q == IDLE) && start_i) || (state_q == CALC) || (state_q == CORR));

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle execute unit for the RV32M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in the EX stage and receives the same decoded operands from id_ex.
- Stalls the pipeline through ctrl via hold_flag_o while it iterates.
- Generalised in operand width; iterative shift-add multiply and restoring divide, one bit per cycle.

Parameters:
XLEN, 32, operand and result width in bits (>= 8).
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
start_i  input  1  EX holds an M-type instruction (opcode 0110011, func7 0000001)
op_i  input  3  func3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op1_i  input  XLEN  rs1 value
op2_i  input  XLEN  rs2 value
rd_addr_i  input  5  destination register
flush_i  input  1  jump/flush from ctrl; cancels the operation in flight
rd_data_o  output  XLEN  result, valid while rd_wen_o=1
rd_addr_o  output  5  destination latched at start
rd_wen_o  output  1  one-cycle write-back strobe
busy_o  output  1  state is not IDLE
hold_flag_o  output  1  stall request to ctrl

Behaviour:
- States: IDLE, CALC, CORR, DONE.
- Reset (async, rst_n=0): state IDLE; rd_data_o, rd_addr_o, rd_wen_o, busy_o, counter and all datapath registers = 0.
- Reset mid-operation aborts immediately with no write-back.
- IDLE + start_i:
  - Latch op_i, rd_addr_i, |op1|, |op2| and sign flags.
  - Signed operands: MULH/DIV/REM both; MULHSU op1 only.
  - Go to CALC with counter = 0.
- IDLE + start_i, special divide cases, go straight to DONE:
  - DIV/DIVU by zero: result all ones.
  - REM/REMU by zero: result = op1_i.
  - DIV with op1 = 1<<(XLEN-1) and op2 = all ones: result op1_i; REM gives 0.
- CALC:
  - One iteration per cycle.
  - Multiply: 2*XLEN-bit product accumulates by shift-add.
  - Divide: restoring shift-subtract on XLEN-bit remainder and quotient.
  - Counter increments each cycle; after XLEN iterations go to CORR.
- CORR, one cycle:
  - Product negated if operand signs differ.
  - Quotient negated if signs differ; remainder takes the sign of the dividend.
  - MUL selects product[XLEN-1:0]; MULH/MULHSU/MULHU select product[2XLEN-1:XLEN].
  - Go to DONE.
- DONE, one cycle:
  - rd_wen_o = 1; rd_data_o and rd_addr_o are valid.
  - Next state IDLE, or CALC if start_i is high (back-to-back accepted, same rules as IDLE).
- Latency, counting the start_i cycle as cycle 0:
  - Normal operation: rd_wen_o high in cycle XLEN+2 (cycle 34 for XLEN=32).
  - Special cases: rd_wen_o high in cycle 1.
- hold_flag_o = (state==IDLE & start_i & ~flush_i) | state==CALC | state==CORR.
  - Low in DONE so the pipeline advances in the write-back cycle.
- start_i is ignored in CALC and CORR.
- flush_i, in any state:
  - Next state IDLE; rd_wen_o stays 0.
  - Has priority over start_i in the same cycle.
  - hold_flag_o drops in the same cycle, combinationally.
- Outputs rd_addr_o and rd_data_o hold their last values outside DONE. Only rd_wen_o qualifies them.
- All arithmetic is modulo 2^XLEN, except the 2*XLEN-bit product register.

Test Plan:
- MUL 7 * 0xFFFFFFFD -> rd_data_o=0xFFFFFFEB, rd_wen_o high cycle 34, hold_flag_o high cycles 0-33 then low.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, rd_wen_o in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- flush_i pulsed at cycle 10 of a DIV -> no rd_wen_o, busy_o=0 from cycle 11; new start at cycle 12 completes at cycle 46 with correct result.
- rst_n low mid-CALC -> all outputs 0 immediately. Separately, start_i held high in DONE -> second op accepted, second rd_wen_o 34 cycles after the first. Rerun MUL/DIV with XLEN=16 -> latency 18.
